// File: rtl/evu_pkg.sv
// Shared definitions for the event counter: register map, privilege encoding, packed field types.
// Pure declarations; no logic, no latency, no backpressure.
package evu_pkg;

    localparam logic [3:0] EVU_ADDR_CTRL       = 4'h0;
    localparam logic [3:0] EVU_ADDR_PRIV_MASK  = 4'h1;
    localparam logic [3:0] EVU_ADDR_STATUS     = 4'h2;
    localparam logic [3:0] EVU_ADDR_COUNT0     = 4'h4;
    localparam logic [3:0] EVU_ADDR_THRESH0    = 4'h8;
    localparam logic [3:0] EVU_ADDR_ASID_MATCH = 4'hC;

    localparam logic [1:0] EVU_PRIV_INV = 2'b00;
    localparam logic [1:0] EVU_PRIV_M   = 2'b01;
    localparam logic [1:0] EVU_PRIV_S   = 2'b10;
    localparam logic [1:0] EVU_PRIV_U   = 2'b11;

    localparam int EVU_ASID_WIDTH = 16;

    typedef struct packed {
        logic [1:0]                priv;
        logic [EVU_ASID_WIDTH-1:0] asid;
    } evu_e_info_t;

    typedef struct packed {
        logic [3:0] irq_en;
        logic [3:0] en;
    } evu_ctrl_t;

    typedef struct packed {
        logic [3:0] ovf;
        logic [3:0] thr;
    } evu_status_t;

    // One-hot {U,S,M} select lining up with a line's 3-bit PRIV_MASK field; invalid priv selects nothing.
    function automatic logic [2:0] evu_priv_sel(input logic [1:0] priv);
        logic [2:0] sel;
        sel = 3'b000;
        case (priv)
            EVU_PRIV_M: sel = 3'b001;
            EVU_PRIV_S: sel = 3'b010;
            EVU_PRIV_U: sel = 3'b100;
            default:    sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/evu_cnt_slice.sv
// One event counter with threshold register; software writes override a same-cycle increment.
// Counter updates on the edge after inc_i; thr/ovf set pulses are combinational; no backpressure.
module evu_cnt_slice #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 cnt_we_i,
    input  logic                 thr_we_i,
    input  logic [CNT_WIDTH-1:0] wdata_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] thresh_o,
    output logic                 thr_set_o,
    output logic                 ovf_set_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] thresh_q, thresh_d;
    logic [CNT_WIDTH-1:0] count_inc;

    assign count_inc = count_q + CNT_WIDTH'(1);

    always_comb begin
        count_d   = count_q;
        thresh_d  = thresh_q;
        thr_set_o = 1'b0;
        ovf_set_o = 1'b0;
        // A dropped increment raises no flags either.
        if (cnt_we_i) begin
            count_d = wdata_i;
        end else if (inc_i) begin
            count_d   = count_inc;
            ovf_set_o = &count_q;
            thr_set_o = (thresh_q != '0) && (count_inc == thresh_q);
        end
        if (thr_we_i) begin
            thresh_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            thresh_q <= '0;
        end else begin
            count_q  <= count_d;
            thresh_q <= thresh_d;
        end
    end

    assign count_o  = count_q;
    assign thresh_o = thresh_q;

endmodule

// File: rtl/evu_event_counter.sv
// Filters event lines by source/privilege (optional ASID via EVU_CNT_ASID_FILTER_EN) into per-line counters with threshold/overflow IRQ.
// Events count one edge after being registered, irq_o one edge after STATUS; no backpressure, every event is taken.
module evu_event_counter
    import evu_pkg::*;
#(
    parameter int   NUM_EVENTS = 4,
    parameter int   CNT_WIDTH  = 32,
    parameter int   ASID_WIDTH = 16,
    parameter logic SRC_ID     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVENTS-1:0] e_id_i,
    input  logic [ASID_WIDTH+1:0] e_info_i,
    input  logic                  s_id_i,
    input  logic                  cfg_we_i,
    input  logic [3:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  irq_o
);

    localparam logic [3:0] LINE_MASK = 4'((1 << NUM_EVENTS) - 1);

    logic [NUM_EVENTS-1:0]   e_id_q;
    logic [ASID_WIDTH+1:0]   e_info_q;
    logic                    s_id_q;
    evu_ctrl_t               ctrl_q, ctrl_d;
    logic [3*NUM_EVENTS-1:0] priv_mask_q, priv_mask_d;
    evu_status_t             status_q, status_d;
    logic                    irq_q, irq_d;

    logic [NUM_EVENTS-1:0]   inc, thr_set, ovf_set;
    logic [CNT_WIDTH-1:0]    count  [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]    thresh [NUM_EVENTS];
    logic [2:0]              priv_sel;
    logic                    src_ok, asid_ok;

    assign priv_sel = evu_priv_sel(e_info_q[ASID_WIDTH +: 2]);
    assign src_ok   = (s_id_q == SRC_ID);

`ifdef EVU_CNT_ASID_FILTER_EN
    logic                  asid_en_q;
    logic [ASID_WIDTH-1:0] asid_val_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            asid_en_q  <= 1'b0;
            asid_val_q <= '0;
        end else if (cfg_we_i && cfg_addr_i == EVU_ADDR_ASID_MATCH) begin
            asid_en_q  <= cfg_wdata_i[31];
            asid_val_q <= cfg_wdata_i[ASID_WIDTH-1:0];
        end
    end

    assign asid_ok = !asid_en_q || (e_info_q[ASID_WIDTH-1:0] == asid_val_q);
`else
    logic unused_asid;
    assign unused_asid = ^e_info_q[ASID_WIDTH-1:0];
    assign asid_ok     = 1'b1;
`endif

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_line
        localparam logic [3:0] CNT_ADDR = EVU_ADDR_COUNT0 + 4'(g);
        localparam logic [3:0] THR_ADDR = EVU_ADDR_THRESH0 + 4'(g);

        assign inc[g] = e_id_q[g] & ctrl_q.en[g] & src_ok & asid_ok
                      & (|(priv_mask_q[3*g +: 3] & priv_sel));

        evu_cnt_slice #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slice (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc[g]),
            .cnt_we_i  (cfg_we_i && cfg_addr_i == CNT_ADDR),
            .thr_we_i  (cfg_we_i && cfg_addr_i == THR_ADDR),
            .wdata_i   (cfg_wdata_i[CNT_WIDTH-1:0]),
            .count_o   (count[g]),
            .thresh_o  (thresh[g]),
            .thr_set_o (thr_set[g]),
            .ovf_set_o (ovf_set[g])
        );
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        priv_mask_d = priv_mask_q;
        status_d    = status_q;
        if (cfg_we_i && cfg_addr_i == EVU_ADDR_CTRL) begin
            ctrl_d.en     = cfg_wdata_i[3:0] & LINE_MASK;
            ctrl_d.irq_en = cfg_wdata_i[7:4] & LINE_MASK;
        end
        if (cfg_we_i && cfg_addr_i == EVU_ADDR_PRIV_MASK) begin
            priv_mask_d = cfg_wdata_i[3*NUM_EVENTS-1:0];
        end
        if (cfg_we_i && cfg_addr_i == EVU_ADDR_STATUS) begin
            status_d.thr = status_d.thr & ~cfg_wdata_i[3:0];
            status_d.ovf = status_d.ovf & ~cfg_wdata_i[7:4];
        end
        // Hardware set lands after the clear so a coincident set wins.
        status_d.thr = status_d.thr | 4'(thr_set);
        status_d.ovf = status_d.ovf | 4'(ovf_set);
        irq_d        = |((status_q.thr | status_q.ovf) & ctrl_q.irq_en);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e_id_q      <= '0;
            e_info_q    <= '0;
            s_id_q      <= 1'b0;
            ctrl_q      <= '0;
            priv_mask_q <= '0;
            status_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            e_id_q      <= e_id_i;
            e_info_q    <= e_info_i;
            s_id_q      <= s_id_i;
            ctrl_q      <= ctrl_d;
            priv_mask_q <= priv_mask_d;
            status_q    <= status_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            EVU_ADDR_CTRL:      cfg_rdata_o[7:0] = ctrl_q;
            EVU_ADDR_PRIV_MASK: cfg_rdata_o[3*NUM_EVENTS-1:0] = priv_mask_q;
            EVU_ADDR_STATUS:    cfg_rdata_o[7:0] = status_q;
`ifdef EVU_CNT_ASID_FILTER_EN
            EVU_ADDR_ASID_MATCH: begin
                cfg_rdata_o[31]             = asid_en_q;
                cfg_rdata_o[ASID_WIDTH-1:0] = asid_val_q;
            end
`endif
            default:            cfg_rdata_o = '0;
        endcase
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (cfg_addr_i == EVU_ADDR_COUNT0 + 4'(i)) cfg_rdata_o[CNT_WIDTH-1:0] = count[i];
            if (cfg_addr_i == EVU_ADDR_THRESH0 + 4'(i)) cfg_rdata_o[CNT_WIDTH-1:0] = thresh[i];
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_evu_event_counter.sv
// Randomized and directed bench for evu_event_counter against a behavioural register/counter model.
module tb_evu_event_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  e_id;
    logic [17:0] e_info;
    logic        s_id;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    evu_event_counter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .e_id_i      (e_id),
        .e_info_i    (e_info),
        .s_id_i      (s_id),
        .cfg_we_i    (we),
        .cfg_addr_i  (addr),
        .cfg_wdata_i (wdata),
        .cfg_rdata_o (rdata),
        .irq_o       (irq)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Behavioural model: architectural registers plus last cycle's sampled event inputs.
    bit [31:0] m_cnt [4];
    bit [31:0] m_thr [4];
    bit [3:0]  m_en, m_ie, m_st_thr, m_st_ovf;
    bit [11:0] m_pm;
    bit        m_irq;
    bit        m_asid_en;
    bit [15:0] m_asid;
    bit [3:0]  p_eid;
    bit [1:0]  p_priv;
    bit [15:0] p_asid;
    bit        p_sid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [3:0] a);
        case (a)
            4'h0: return {24'd0, m_ie, m_en};
            4'h1: return {20'd0, m_pm};
            4'h2: return {24'd0, m_st_ovf, m_st_thr};
            4'h4, 4'h5, 4'h6, 4'h7: return m_cnt[a - 4'h4];
            4'h8, 4'h9, 4'hA, 4'hB: return m_thr[a - 4'h8];
`ifdef EVU_CNT_ASID_FILTER_EN
            4'hC: return {m_asid_en, 15'd0, m_asid};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_thr[i] = 0;
        end
        m_en = 0; m_ie = 0; m_st_thr = 0; m_st_ovf = 0; m_pm = 0; m_irq = 0;
        m_asid_en = 0; m_asid = 0;
        p_eid = 0; p_priv = 0; p_asid = 0; p_sid = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit [3:0] thr_hit, ovf_hit;
        bit       counts;
        int       line;
        if (!rst_n) begin
            model_reset();
            return;
        end
        thr_hit = 0;
        ovf_hit = 0;
        for (int i = 0; i < 4; i++) begin
            counts = p_eid[i] && m_en[i] && (p_sid == 1'b0) && (p_priv != 2'b00)
                     && m_pm[3*i + int'(p_priv) - 1];
`ifdef EVU_CNT_ASID_FILTER_EN
            if (m_asid_en && p_asid != m_asid) counts = 0;
`endif
            if (we && addr == 4'(4 + i)) begin
                m_cnt[i] = wdata;
            end else if (counts) begin
                if (m_cnt[i] == 32'hFFFF_FFFF) ovf_hit[i] = 1;
                m_cnt[i] = m_cnt[i] + 1;
                if (m_thr[i] != 0 && m_cnt[i] == m_thr[i]) thr_hit[i] = 1;
            end
        end
        m_irq = |((m_st_thr | m_st_ovf) & m_ie);
        if (we) begin
            line = int'(addr) & 3;
            case (addr)
                4'h0: begin m_en = wdata[3:0]; m_ie = wdata[7:4]; end
                4'h1: m_pm = wdata[11:0];
                4'h2: begin m_st_thr &= ~wdata[3:0]; m_st_ovf &= ~wdata[7:4]; end
                4'h8, 4'h9, 4'hA, 4'hB: m_thr[line] = wdata;
`ifdef EVU_CNT_ASID_FILTER_EN
                4'hC: begin m_asid_en = wdata[31]; m_asid = wdata[15:0]; end
`endif
                default: ;
            endcase
        end
        m_st_thr |= thr_hit;
        m_st_ovf |= ovf_hit;
        p_eid  = e_id;
        p_priv = e_info[17:16];
        p_asid = e_info[15:0];
        p_sid  = s_id;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wr(input bit [3:0] a, input bit [31:0] d);
        we = 1; addr = a; wdata = d;
        tick();
        we = 0;
    endtask

    task automatic ev(input int n, input bit [3:0] lines, input bit [1:0] priv, input bit [15:0] asid, input bit sid);
        for (int k = 0; k < n; k++) begin
            e_id = lines; e_info = {priv, asid}; s_id = sid;
            tick();
        end
        e_id = 0; s_id = 0;
    endtask

    task automatic flush();
        e_id = 0; we = 0;
        tick();
        tick();
    endtask

    task automatic rd(input bit [3:0] a, input string tag, input bit [31:0] exp);
        we = 0; addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_all_model();
        for (int a = 0; a < 16; a++) rd(4'(a), "reg_vs_model", m_read(4'(a)));
    endtask

    initial begin
        rst_n = 0; e_id = 0; e_info = 0; s_id = 0; we = 0; addr = 0; wdata = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
        for (int a = 0; a < 16; a++) rd(4'(a), "reset_reg", 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // Privilege filtering on line 0.
        wr(4'h0, 32'h01);
        wr(4'h1, 32'h1);
        ev(5, 4'h1, 2'b01, 16'h0, 1'b0);
        ev(3, 4'h1, 2'b11, 16'h0, 1'b0);
        flush();
        rd(4'h4, "filt_cnt0", 32'd5);
        rd(4'h5, "filt_cnt1", 32'd0);
        rd(4'h6, "filt_cnt2", 32'd0);
        rd(4'h7, "filt_cnt3", 32'd0);

        // Threshold on line 1 raising and clearing the interrupt.
        wr(4'h9, 32'd3);
        wr(4'h0, 32'h22);
        wr(4'h1, 32'h38);
        ev(3, 4'h2, 2'b10, 16'h0, 1'b0);
        tick();
        rd(4'h2, "thr_status", 32'h02);
        tick();
        chk("thr_irq_set", {31'd0, irq}, 32'd1);
        wr(4'h2, 32'h02);
        tick();
        chk("thr_irq_clr", {31'd0, irq}, 32'd0);

        // Wrap-around on line 2.
        wr(4'h6, 32'hFFFF_FFFF);
        wr(4'h0, 32'h04);
        wr(4'h1, 32'hFFF);
        ev(1, 4'h4, 2'b01, 16'h0, 1'b0);
        flush();
        rd(4'h6, "wrap_cnt2", 32'd0);
        rd(4'h2, "wrap_status", 32'h40);

        // Software write coinciding with an increment on line 3.
        wr(4'h0, 32'h08);
        ev(1, 4'h8, 2'b01, 16'h0, 1'b0);
        wr(4'h7, 32'h10);
        flush();
        rd(4'h7, "wr_wins_cnt3", 32'h10);

        // Source and invalid-priv rejection.
        wr(4'h0, 32'hFF);
        wr(4'h2, 32'hFF);
        ev(4, 4'hF, 2'b01, 16'h0, 1'b1);
        ev(4, 4'hF, 2'b00, 16'h0, 1'b0);
        flush();
        rd(4'h4, "rej_cnt0", 32'd5);
        rd(4'h5, "rej_cnt1", 32'd3);
        rd(4'h6, "rej_cnt2", 32'd0);
        rd(4'h7, "rej_cnt3", 32'h10);

`ifdef EVU_CNT_ASID_FILTER_EN
        wr(4'hC, 32'h8000_0005);
        wr(4'h4, 32'd0);
        ev(1, 4'h1, 2'b01, 16'd5, 1'b0);
        ev(1, 4'h1, 2'b01, 16'd6, 1'b0);
        ev(1, 4'h1, 2'b01, 16'd5, 1'b0);
        flush();
        rd(4'h4, "asid_cnt0", 32'd2);
        wr(4'hC, 32'h0);
`endif
        chk_all_model();

        // Reset pulse while events stream in.
        wr(4'h2, 32'h0);
        e_id = 4'hF; e_info = {2'b01, 16'd0};
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; e_id = 0;
        tick();
        for (int a = 0; a < 16; a++) rd(4'(a), "midrst_reg", 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n  = ($urandom_range(0, 399) != 0);
            e_id   = 4'($urandom);
            e_info = {2'($urandom), 16'($urandom_range(4, 6))};
            s_id   = ($urandom_range(0, 5) == 0);
            we     = ($urandom_range(0, 3) == 0);
            addr   = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
                1:       wdata = $urandom;
                default: wdata = $urandom_range(0, 15);
            endcase
            if (addr == 4'hC) wdata[31] = $urandom_range(0, 1);
            #1;
            chk("rand_rdata", rdata, m_read(addr));
            tick();
        end
        rst_n = 1;
        flush();
        chk_all_model();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
